// File: rtl/rf_writeback_pkg.sv
// Shared definitions for the register-file writeback stage.
// Holds the source, destination and load-type encodings, the FSM state type,
// the default widths and the link register number.
`timescale 1ns/1ps

package rf_writeback_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int LINK_REG = 31;

    // Result source. The reserved code behaves like ALU.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;

    // Destination register select. NONE suppresses the write.
    typedef enum logic [1:0] {
        DST_SEL_RT   = 2'd0,
        DST_SEL_RD   = 2'd1,
        DST_SEL_RA   = 2'd2,
        DST_SEL_NONE = 2'd3
    } dst_sel_e;

    // Load width/extension. Codes 5..7 behave like LW.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FORMAT = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } wb_state_e;

endpackage

// File: rtl/rf_writeback_if.sv
// Upstream retirement handshake between the control FSM (master) and the
// writeback stage (slave).
//   wb_valid/wb_ready : accept handshake
//   wb_sel, dst_sel   : source and destination selects
//   rt, rd            : instruction register fields
//   alu_res, mem_data, pc_plus4 : candidate result values
//   ld_type, byte_off : load extension controls
`timescale 1ns/1ps

interface rf_writeback_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_sel;
    logic [1:0]    dst_sel;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] pc_plus4;
    logic [2:0]    ld_type;
    logic [1:0]    byte_off;

    modport master (
        output wb_valid, wb_sel, dst_sel, rt, rd,
               alu_res, mem_data, pc_plus4, ld_type, byte_off,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_sel, dst_sel, rt, rd,
               alu_res, mem_data, pc_plus4, ld_type, byte_off,
        output wb_ready
    );
endinterface

// File: rtl/rf_writeback_load_ext.sv
// load_ext: combinational load extractor/extender.
//   mem_data : raw aligned word from data memory
//   ld_type  : LW / LB / LBU / LH / LHU (other codes act as LW)
//   byte_off : load address [1:0]; only bit 1 matters for halfwords
//   data     : extended word for the register file
`timescale 1ns/1ps

module load_ext
    import rf_writeback_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] mem_data,
    input  logic [2:0]    ld_type,
    input  logic [1:0]    byte_off,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = mem_data[{byte_off, 3'b000} +: 8];
    assign half_v = mem_data[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: default assignment first so no path leaves data unassigned (no latch).
        data = mem_data;
        case (ld_type)
            LD_LB:   data = {{(DW-8){byte_v[7]}}, byte_v};
            LD_LBU:  data = {{(DW-8){1'b0}}, byte_v};
            LD_LH:   data = {{(DW-16){half_v[15]}}, half_v};
            LD_LHU:  data = {{(DW-16){1'b0}}, half_v};
            default: data = mem_data;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: writeback stage in front of the register file.
// Accepts one retiring result per handshake, selects source and destination,
// extends loads, and drives the register-file write port with a one-cycle
// strobe. Sequence: IDLE -> FORMAT -> COMMIT -> HOLD -> IDLE.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   wb           : upstream handshake (rf_writeback_if.slave)
//   rf_a3, rf_wd : register-file write address / data (held between writes)
//   rf_wr        : register-file write enable, high only in COMMIT
//   wb_done      : one-cycle retirement pulse in HOLD
//   byp_valid, byp_addr, byp_data : pending-write bypass for decode
// Configuration: define RF_WB_BYPASS_EN to enable the bypass outputs;
// otherwise they are tied to zero.
`timescale 1ns/1ps

module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    rf_writeback_if.slave wb,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    output logic          rf_wr,
    output logic          wb_done,
    output logic          byp_valid,
    output logic [AW-1:0] byp_addr,
    output logic [DW-1:0] byp_data
);

    wb_state_e     state;
    logic          ready_q;
    logic          accept;

    // Captured transaction.
    wb_sel_e       sel_q;
    dst_sel_e      dst_q;
    logic [AW-1:0] rt_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] pc_q;
    logic [2:0]    ld_q;
    logic [1:0]    off_q;

    // Formatted result derived from the captured transaction.
    logic [DW-1:0] ext_data;
    logic [AW-1:0] fmt_addr;
    logic [DW-1:0] fmt_data;
    logic          fmt_we;

    assign wb.wb_ready = ready_q;
    assign accept      = ready_q && wb.wb_valid;

    // NOTE: capture registers carry no reset; they are only consumed after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_q <= wb_sel_e'(wb.wb_sel);
            dst_q <= dst_sel_e'(wb.dst_sel);
            rt_q  <= wb.rt;
            rd_q  <= wb.rd;
            alu_q <= wb.alu_res;
            mem_q <= wb.mem_data;
            pc_q  <= wb.pc_plus4;
            ld_q  <= wb.ld_type;
            off_q <= wb.byte_off;
        end
    end

    load_ext #(.DW(DW)) u_load_ext (
        .mem_data (mem_q),
        .ld_type  (ld_q),
        .byte_off (off_q),
        .data     (ext_data)
    );

    always_comb begin
        fmt_addr = '0;
        case (dst_q)
            DST_SEL_RT: fmt_addr = rt_q;
            DST_SEL_RD: fmt_addr = rd_q;
            DST_SEL_RA: fmt_addr = AW'(LINK_REG);
            default:    fmt_addr = '0;
        endcase
    end

    always_comb begin
        fmt_data = alu_q;
        case (sel_q)
            WB_SEL_MEM:  fmt_data = ext_data;
            WB_SEL_LINK: fmt_data = pc_q;
            default:     fmt_data = alu_q;
        endcase
    end

    // Writes to $0 or with no destination are dropped.
    assign fmt_we = (dst_q != DST_SEL_NONE) && (fmt_addr != '0);

    // All FSM outputs are registered so the write port sees clean levels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            rf_a3   <= '0;
            rf_wd   <= '0;
            rf_wr   <= 1'b0;
            wb_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every state register updates from pre-edge values.
            case (state)
                ST_IDLE: begin
                    wb_done <= 1'b0;
                    if (wb.wb_valid) begin
                        ready_q <= 1'b0;
                        state   <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    rf_a3 <= fmt_addr;
                    rf_wd <= fmt_data;
                    rf_wr <= fmt_we;
                    state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    rf_wr   <= 1'b0;
                    wb_done <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    wb_done <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    rf_wr   <= 1'b0;
                    wb_done <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Capture registers are stable from FORMAT through HOLD, so the formatted
    // values double as the pending write while the stage is busy.
    assign byp_valid = !ready_q && fmt_we;
    assign byp_addr  = byp_valid ? fmt_addr : '0;
    assign byp_data  = byp_valid ? fmt_data : '0;
`else
    assign byp_valid = 1'b0;
    assign byp_addr  = '0;
    assign byp_data  = '0;
`endif

endmodule
